// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : div_arbiter
//  Purpose  : Shares one multi-cycle divider between two issue slots.
//             Selects one requester and hands its operands to the divider.
//             Returns the 64-bit result to that requester with a one-cycle
//             done pulse.
//             While the divider is busy, a slot that is requesting sees stall.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    PRIO_SLOT0   1 = slot 0 always wins a tie, 0 = round-robin between slots
//  Optional feature
//    DIV_RESULT_CACHE_EN  when defined, a one-entry result cache lets an exact
//                         repeat of the last completed division skip the
//                         divider and complete in one cycle
//  Ports
//    clk, rst                     clock, synchronous active-high reset
//    req{0,1}_valid/_signed/_a/_b slot requests and operands
//    flush                        abandons any operation in progress
//    stall0/stall1                slot must hold its instruction
//    done0/done1                  one-cycle result-valid pulse per slot
//    result                       {remainder, quotient}
//    div_start/_signed/_opa/_opb  command to the shared divider
//    div_annul                    cancels the divider's current operation
//    div_result, div_ready        response from the shared divider
// ============================================================================
module div_arbiter #(
  parameter int PRIO_SLOT0 = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic        req0_signed,
  input  logic        req1_signed,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        flush,
  output logic        stall0,
  output logic        stall1,
  output logic        done0,
  output logic        done1,
  output logic [63:0] result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_BUSY = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;

  logic [1:0]  r_state;
  logic        r_owner;       // 0 = slot 0, 1 = slot 1
  logic        r_signed;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [63:0] r_result;
  logic        r_last_grant;  // slot granted most recently

  logic        w_req_any;
  logic        w_grant1;      // winner of this cycle's arbitration is slot 1
  logic        w_win_signed;
  logic [31:0] w_win_a;
  logic [31:0] w_win_b;
  logic        w_done;

  assign w_req_any = req0_valid | req1_valid;

  // w_grant1 is only consumed when at least one slot is requesting.
  always_comb begin
    w_grant1 = 1'b0;
    if (PRIO_SLOT0 != 0) begin
      w_grant1 = ~req0_valid;
    end else if (req0_valid && req1_valid) begin
      w_grant1 = ~r_last_grant;
    end else begin
      w_grant1 = ~req0_valid;
    end
  end

  assign w_win_signed = w_grant1 ? req1_signed : req0_signed;
  assign w_win_a      = w_grant1 ? req1_a      : req0_a;
  assign w_win_b      = w_grant1 ? req1_b      : req0_b;

`ifdef DIV_RESULT_CACHE_EN
  logic        r_cache_valid;
  logic        r_cache_signed;
  logic [31:0] r_cache_a;
  logic [31:0] r_cache_b;
  logic [63:0] r_cache_result;
  logic        w_cache_hit;

  assign w_cache_hit = r_cache_valid && (r_cache_signed == w_win_signed) &&
                       (r_cache_a == w_win_a) && (r_cache_b == w_win_b);

  // Captured only for divisions that actually complete; flush leaves the
  // entry intact because the stored result is still arithmetically correct.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cache_valid  <= 1'b0;
      r_cache_signed <= 1'b0;
      r_cache_a      <= 32'h0;
      r_cache_b      <= 32'h0;
      r_cache_result <= 64'h0;
    end else if (r_state == C_BUSY && !flush && div_ready) begin
      r_cache_valid  <= 1'b1;
      r_cache_signed <= r_signed;
      r_cache_a      <= r_a;
      r_cache_b      <= r_b;
      r_cache_result <= div_result;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= C_IDLE;
      r_owner      <= 1'b0;
      r_signed     <= 1'b0;
      r_a          <= 32'h0;
      r_b          <= 32'h0;
      r_result     <= 64'h0;
      r_last_grant <= 1'b1;   // slot 0 wins the first round-robin tie
    end else begin
      case (r_state)
        C_IDLE: begin
          if (w_req_any && !flush) begin
            r_owner      <= w_grant1;
            r_signed     <= w_win_signed;
            r_a          <= w_win_a;
            r_b          <= w_win_b;
            r_last_grant <= w_grant1;
`ifdef DIV_RESULT_CACHE_EN
            if (w_cache_hit) begin
              r_result <= r_cache_result;
              r_state  <= C_DONE;
            end else begin
              r_state  <= C_BUSY;
            end
`else
            r_state      <= C_BUSY;
`endif
          end
        end
        C_BUSY: begin
          // Flush wins over a coincident div_ready: the result is dropped.
          if (flush) begin
            r_state <= C_IDLE;
          end else if (div_ready) begin
            r_result <= div_result;
            r_state  <= C_DONE;
          end
        end
        C_DONE: begin
          r_state <= C_IDLE;
        end
        default: begin
          r_state <= C_IDLE;
        end
      endcase
    end
  end

  // Divider command is withdrawn in the same cycle a flush arrives, and the
  // annul pulse is naturally one cycle long because BUSY is left next edge.
  assign div_start  = (r_state == C_BUSY) & ~flush;
  assign div_annul  = (r_state == C_BUSY) &  flush;
  assign div_signed = r_signed;
  assign div_opa    = r_a;
  assign div_opb    = r_b;

  assign w_done = (r_state == C_DONE) & ~flush;
  assign done0  = w_done & ~r_owner;
  assign done1  = w_done &  r_owner;

  assign stall0 = req0_valid & ~done0;
  assign stall1 = req1_valid & ~done1;

  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_arbiter
//  Purpose  : Self-checking bench for div_arbiter. Two instances: fixed
//             priority (default) and round-robin. Each has a behavioural
//             divider with fixed latency attached.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_arbiter;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- fixed-priority instance ----------------
  logic        req0_valid, req1_valid, req0_signed, req1_signed, flush;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        stall0, stall1, done0, done1;
  logic        div_start, div_signed, div_annul;
  logic [31:0] div_opa, div_opb;
  logic [63:0] result;
  logic [63:0] div_result = 64'h0;
  logic        div_ready  = 1'b0;
  int          dcnt       = 0;

  div_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_signed(req0_signed), .req1_signed(req1_signed),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .flush(flush),
    .stall0(stall0), .stall1(stall1), .done0(done0), .done1(done1),
    .result(result),
    .div_start(div_start), .div_signed(div_signed),
    .div_opa(div_opa), .div_opb(div_opb), .div_annul(div_annul),
    .div_result(div_result), .div_ready(div_ready)
  );

  // ---------------- round-robin instance ----------------
  logic        rr_req0_valid, rr_req1_valid;
  logic [31:0] rr_req0_a, rr_req0_b, rr_req1_a, rr_req1_b;
  logic        rr_stall0, rr_stall1, rr_done0, rr_done1;
  logic        rr_div_start, rr_div_signed, rr_div_annul;
  logic [31:0] rr_div_opa, rr_div_opb;
  logic [63:0] rr_result;
  logic [63:0] rr_div_result = 64'h0;
  logic        rr_div_ready  = 1'b0;
  int          rr_dcnt       = 0;

  div_arbiter #(.PRIO_SLOT0(0)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(rr_req0_valid), .req1_valid(rr_req1_valid),
    .req0_signed(1'b0), .req1_signed(1'b0),
    .req0_a(rr_req0_a), .req0_b(rr_req0_b), .req1_a(rr_req1_a), .req1_b(rr_req1_b),
    .flush(1'b0),
    .stall0(rr_stall0), .stall1(rr_stall1), .done0(rr_done0), .done1(rr_done1),
    .result(rr_result),
    .div_start(rr_div_start), .div_signed(rr_div_signed),
    .div_opa(rr_div_opa), .div_opb(rr_div_opb), .div_annul(rr_div_annul),
    .div_result(rr_div_result), .div_ready(rr_div_ready)
  );

  // Reference divider: divide by zero yields all-ones quotient, remainder = a.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, b);
    logic signed [31:0] sa, sb, q, r;
    if (b == 32'h0) return {a, 32'hFFFFFFFF};
    if (sgn) begin
      sa = a; sb = b; q = sa / sb; r = sa % sb;
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  always @(posedge clk) begin
    if (rst || div_annul) begin
      dcnt <= 0; div_ready <= 1'b0;
    end else if (div_ready) begin
      dcnt <= 0; div_ready <= 1'b0;
    end else if (div_start) begin
      if (dcnt == LAT - 1) begin
        div_ready  <= 1'b1;
        div_result <= ref_div(div_signed, div_opa, div_opb);
        dcnt       <= 0;
      end else dcnt <= dcnt + 1;
    end
  end

  always @(posedge clk) begin
    if (rst || rr_div_annul) begin
      rr_dcnt <= 0; rr_div_ready <= 1'b0;
    end else if (rr_div_ready) begin
      rr_dcnt <= 0; rr_div_ready <= 1'b0;
    end else if (rr_div_start) begin
      if (rr_dcnt == LAT - 1) begin
        rr_div_ready  <= 1'b1;
        rr_div_result <= ref_div(rr_div_signed, rr_div_opa, rr_div_opb);
        rr_dcnt       <= 0;
      end else rr_dcnt <= rr_dcnt + 1;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered and left just after a rising edge. Holds the request until the
  // slot's done pulse is seen, bounded to 40 cycles.
  task automatic issue(input int slot, input logic sgn, input logic [31:0] a, b,
                       output logic [63:0] res, output int cyc, output int starts,
                       output int both);
    cyc = -1; starts = 0; both = 0; res = '0;
    if (slot == 0) begin
      req0_valid = 1'b1; req0_signed = sgn; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_signed = sgn; req1_a = a; req1_b = b;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (div_start) starts++;
      if (done0 && done1) both++;
      if ((slot == 0 && done0) || (slot == 1 && done1)) begin
        cyc = i; res = result;
      end
      @(posedge clk); #1;
      if (cyc >= 0) break;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Slot-0 request with a one-cycle flush in cycle k (request cycle = 0).
  task automatic flush_run(input int k, input logic [31:0] a,
                           output int annul_k, output int start_k,
                           output int dones, output int state_next);
    annul_k = -1; start_k = -1; dones = 0; state_next = -1;
    req0_valid = 1'b1; req0_signed = 1'b0; req0_a = a; req0_b = 32'd3;
    for (int i = 0; i < 15; i++) begin
      flush = (i == k);
      if (i == k + 1) req0_valid = 1'b0;
      @(negedge clk);
      if (i == k) begin annul_k = int'(div_annul); start_k = int'(div_start); end
      if (i == k + 1) state_next = int'(dut.r_state);
      if (done0) dones++;
      @(posedge clk); #1;
    end
    flush = 1'b0; req0_valid = 1'b0;
  endtask

  typedef struct {
    int          slot;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t        vt[6];
  logic [63:0] res;
  int          cyc, starts, both;
  int          d0, d1, bad, n;
  int          annul_k, start_k, dones, state_next;
  int          order[4];
  logic [63:0] res1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0, 1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
    vt[1] = '{1, 1'b0, 32'd100,      32'd7,        64'h00000002_0000000E};
    vt[2] = '{0, 1'b0, 32'hFFFFFFFF, 32'd2,        64'h00000001_7FFFFFFF};
    vt[3] = '{1, 1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD};
    vt[4] = '{0, 1'b0, 32'd5,        32'd0,        64'h00000005_FFFFFFFF};
    vt[5] = '{1, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E};

    req0_valid = 0; req1_valid = 0; req0_signed = 0; req1_signed = 0; flush = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    rr_req0_valid = 0; rr_req1_valid = 0;
    rr_req0_a = 0; rr_req0_b = 0; rr_req1_a = 0; rr_req1_b = 0;

    // ---- reset state ----
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ctl", {59'h0, done0, done1, div_start, div_annul, div_signed}, 64'h0);
    check("reset_ops", {div_opa, div_opb}, 64'h0);
    check("reset_result", result, 64'h0);
    check("reset_stall", {62'h0, stall0, stall1}, 64'h0);
    check("reset_state", {62'h0, dut.r_state}, 64'h0);
    check("reset_rr", {rr_result[62:0] | {rr_div_opa, rr_div_opb}, rr_done0 | rr_done1 | rr_div_start},
          64'h0);
    @(posedge clk); #1;

    // ---- result cache: same unsigned 100/7 twice ----
    issue(0, 1'b0, 32'd100, 32'd7, res, cyc, starts, both);
    check("cache_first_result", res, 64'h00000002_0000000E);
    check("cache_first_latency", cyc, LAT + 2);
    check("cache_first_starts", starts, LAT + 1);
    issue(0, 1'b0, 32'd100, 32'd7, res, cyc, starts, both);
    check("cache_second_result", res, 64'h00000002_0000000E);
`ifdef DIV_RESULT_CACHE_EN
    check("cache_second_latency", cyc, 1);
    check("cache_second_starts", starts, 0);
`else
    check("cache_second_latency", cyc, LAT + 2);
    check("cache_second_starts", starts, LAT + 1);
`endif

    // ---- both slots at once, fixed priority ----
    req0_valid = 1; req0_signed = 1; req0_a = 32'd7;    req0_b = 32'hFFFFFFFE;
    req1_valid = 1; req1_signed = 0; req1_a = 32'd1000; req1_b = 32'd33;
    d0 = -1; d1 = -1; bad = 0; both = 0; res1 = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done0 && d0 < 0) d0 = i;
      if (done1) begin d1 = i; res1 = result; end
      if (done0 && done1) both++;
      if (d1 < 0 && stall1 !== 1'b1) bad++;
      @(posedge clk); #1;
      if (d0 >= 0) req0_valid = 0;
      if (d1 >= 0) break;
    end
    req0_valid = 0; req1_valid = 0;
    check("prio_done0_cycle", d0, LAT + 2);
    check("prio_done1_cycle", d1, 2 * LAT + 5);
    check("prio_slot1_result", res1, 64'h0000000A_0000001E);
    check("prio_stall1_held", bad, 0);
    check("prio_done_exclusive", both, 0);

    // ---- directed vector table ----
    foreach (vt[i]) begin
      issue(vt[i].slot, vt[i].sgn, vt[i].a, vt[i].b, res, cyc, starts, both);
      check($sformatf("vec%0d_result", i), res, vt[i].exp);
      check($sformatf("vec%0d_latency", i), cyc + 100 * both, LAT + 2);
    end

    // ---- flush in BUSY, coinciding with div_ready, and in DONE ----
    flush_run(3, 32'd30, annul_k, start_k, dones, state_next);
    check("flush_busy_annul", annul_k, 1);
    check("flush_busy_start", start_k, 0);
    check("flush_busy_no_done", dones, 0);
    check("flush_busy_idle_next", state_next, 0);
    flush_run(4, 32'd31, annul_k, start_k, dones, state_next);
    check("flush_ready_annul", annul_k, 1);
    check("flush_ready_no_done", dones, 0);
    check("flush_ready_result_kept", result, 64'hFFFFFFFE_0000000E);
    flush_run(5, 32'd32, annul_k, start_k, dones, state_next);
    check("flush_done_annul", annul_k, 0);
    check("flush_done_no_done", dones, 0);

    // ---- round-robin alternation ----
    rr_req0_valid = 1; rr_req0_a = 32'd50; rr_req0_b = 32'd5;
    rr_req1_valid = 1; rr_req1_a = 32'd60; rr_req1_b = 32'd7;
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (rr_done0 && n < 4) begin order[n] = 0; n++; end
      if (rr_done1 && n < 4) begin order[n] = 1; n++; end
      @(posedge clk); #1;
      if (n >= 4) break;
    end
    rr_req0_valid = 0; rr_req1_valid = 0;
    check("rr_grant_count", n, 4);
    for (int i = 0; i < 4; i++)
      if (i < n) check($sformatf("rr_grant%0d", i), order[i], i % 2);

    // ---- reset in the middle of BUSY ----
    req0_valid = 1; req0_signed = 1; req0_a = 32'd9; req0_b = 32'd2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 0;
    @(negedge clk);
    check("rst_busy_ctl", {59'h0, done0, done1, div_start, div_annul, div_signed}, 64'h0);
    check("rst_busy_ops", {div_opa, div_opb}, 64'h0);
    check("rst_busy_result", result, 64'h0);
    check("rst_busy_state", {62'h0, dut.r_state}, 64'h0);
    @(posedge clk); #1;
    issue(0, 1'b0, 32'd20, 32'd6, res, cyc, starts, both);
    check("post_rst_result", res, 64'h00000002_00000003);
    check("post_rst_latency", cyc, LAT + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 SHALL have parameter PRIO_SLOT0, default 1, meaning 1 = fixed priority to slot 0 and 0 = round-robin between slots.
REQ-002 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req0_valid/req1_valid  in  1 each  slot 0/1 requests a division this cycle.
REQ-005 SHALL have ports req0_signed/req1_signed  in  1 each  1 = signed divide, 0 = unsigned.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  in  32 each  dividend (a) and divisor (b).
REQ-007 SHALL have port flush  in  1  pipeline flush; abandons any operation in progress.
REQ-008 SHALL have ports stall0/stall1  out  1 each  slot must hold its instruction.
REQ-009 SHALL have ports done0/done1  out  1 each  one-cycle pulse marking result valid for that slot.
REQ-010 SHALL have port result  out  64  {remainder[63:32], quotient[31:0]}.
REQ-011 SHALL have ports div_start  out  1,  div_signed  out  1,  div_opa  out  32,  div_opb  out  32,  div_annul  out  1; these drive the shared divider.
REQ-012 SHALL have ports div_result  in  64 and div_ready  in  1; these are returned by the shared divider.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-014 IDLE: on any valid request with flush=0, SHALL select a winner, register {owner, signed, a, b} and go to BUSY next cycle.
REQ-015 Winner selection with PRIO_SLOT0=1 SHALL be slot 0 whenever req0_valid=1.
REQ-016 Winner selection with PRIO_SLOT0=0 SHALL be the slot not granted last when both slots request; last_grant SHALL update on every grant.
REQ-017 BUSY: SHALL hold div_start=1 with div_signed/div_opa/div_opb driven from the registered operands until div_ready=1.
REQ-018 BUSY: on div_ready=1, SHALL register div_result into result and go to DONE.
REQ-019 DONE: SHALL last exactly one cycle, assert done<owner>=1, then return to IDLE.
REQ-020 Latency: request sampled in IDLE at cycle T gives BUSY at T+1; div_ready at cycle R gives done at R+1.
REQ-021 stallN SHALL equal reqN_valid & ~doneN, combinationally.
REQ-022 The losing requester SHALL stay stalled and SHALL be granted in the IDLE cycle after DONE.
REQ-023 Flush in IDLE SHALL block the grant.
REQ-024 Flush in BUSY SHALL pulse div_annul=1 for one cycle, deassert div_start, and return to IDLE with no done.
REQ-025 Flush in DONE SHALL suppress done0/done1 for that cycle.
REQ-026 Flush coinciding with div_ready SHALL take priority: no result register update and no done.
REQ-027 Division by zero SHALL pass the divider output through unmodified; no exception is raised.
REQ-028 done0 and done1 SHALL never be asserted in the same cycle.

Reset
REQ-029 rst SHALL force state IDLE.
REQ-030 rst SHALL force all outputs to 0, including result=64'h0 and div_annul=0.
REQ-031 rst SHALL set last_grant=slot 1, so slot 0 wins the first round-robin tie.
REQ-032 rst SHALL clear the cache valid bit.
REQ-033 rst asserted mid-BUSY SHALL take effect next cycle; the divider shares rst.

Configuration
REQ-034 The optional feature SHALL be controlled by macro DIV_RESULT_CACHE_EN.
REQ-035 With DIV_RESULT_CACHE_EN defined: a one-entry cache {valid, signed, a, b, result} SHALL be written on each completed (unflushed) division.
REQ-036 With DIV_RESULT_CACHE_EN defined: a winner in IDLE matching the cache exactly SHALL go straight to DONE at T+1 with the cached result and no div_start.
REQ-037 With DIV_RESULT_CACHE_EN defined: flush SHALL NOT invalidate the cache.
REQ-038 Without DIV_RESULT_CACHE_EN: no cache storage SHALL exist and every request SHALL pass through BUSY.

Verification
REQ-039 Signed 7 / -2 from slot 0 -> div_start held until ready; done0=1 next cycle; result=64'h00000001_FFFFFFFD.
REQ-040 Both slots valid in the same cycle, PRIO_SLOT0=1 -> slot 0 served first; stall1=1 throughout; slot 1 granted the cycle after done0.
REQ-041 PRIO_SLOT0=0, both slots requesting continuously -> grants alternate 0, 1, 0, 1.
REQ-042 Flush 3 cycles into BUSY -> div_annul pulses one cycle; no done; state IDLE next cycle.
REQ-043 Cache enabled, unsigned 100/7 issued twice -> second done arrives 1 cycle after request, div_start stays 0, result=64'h00000002_0000000E; without the macro, the full divider latency is seen.
REQ-044 rst mid-BUSY -> next cycle all outputs 0 and state IDLE; a new request then completes normally.
